axi_stream_fifo: RTL

- Synchronous first-word-fall-through FIFO with AXI-stream slave input and AXI-stream master output, both on axi_stream_if.
- Buffers data plus last; decouples a producer from a consumer that stalls (ready low).
- Sits directly upstream of any axi_stream_if.slave consumer.
- Exposes fill level and almost-full for upstream flow-control and debug.

---
 rtl/axi_stream_pkg.sv | 11 +
 rtl/axi_stream_if.sv | 16 +
 rtl/axi_stream_fifo_mem.sv | 25 ++
 rtl/axi_stream_fifo.sv | 88 ++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared constants and helpers for the AXI-stream blocks.
package axi_stream_pkg;

  localparam int AXIS_DEFAULT_DATA_WIDTH = 32;

  // Pointer width for a power-of-two depth: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// AXI-stream handshake bundle: data, last and valid from master, ready from slave.
interface axi_stream_if
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/axi_stream_fifo_mem.sv
// Unreset flop array with one synchronous write port and a combinational read port.
module axi_stream_fifo_mem #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_stream_fifo.sv
// First-word-fall-through AXI-stream FIFO carrying data and last, with
// registered fill level and almost-full flag.
module axi_stream_fifo
  import axi_stream_pkg::*;
#(
  parameter int DATA_WIDTH        = AXIS_DEFAULT_DATA_WIDTH,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  axi_stream_if.slave                s_axis,
  axi_stream_if.master               m_axis,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          ready_q;
  logic          empty;
  logic          full_nxt;
  logic          push;
  logic          pop;
  logic [DATA_WIDTH:0] rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign push  = s_axis.valid && ready_q;
  assign pop   = !empty && m_axis.ready;

  assign wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;
  assign full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // ready is a flop of the next-state full flag, so it is low in reset and
  // never depends combinationally on the downstream ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(ALMOST_FULL_LEVEL));
      ready_q     <= !full_nxt;
    end
  end

  axi_stream_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({s_axis.last, s_axis.data}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  assign s_axis.ready = ready_q;
  assign m_axis.valid = !empty;
  assign m_axis.data  = rd_data[DATA_WIDTH-1:0];
  assign m_axis.last  = rd_data[DATA_WIDTH];

endmodule
